// File: rtl/neuron_argmax_pkg.sv
// Shared constants and state encoding for the neuron-layer argmax block.
// Sums are two's-complement 8.18 fixed point.
package neuron_argmax_pkg;

    localparam int NUM_NEURONS  = 10;
    localparam int OUTPUT_WIDTH = 26;
    localparam int IDX_WIDTH    = 4;
    localparam int FRAC_BITS    = 18;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2,
        CLEAR  = 2'd3
    } state_t;

endpackage

// File: rtl/argmax_cmp_sel.sv
// Signed strict-greater compare/select for one argmax step.
// A tie keeps the current best, which always holds the lower index.
module argmax_cmp_sel #(
    parameter int VAL_W = 26,
    parameter int IDX_W = 4
) (
    input  logic [VAL_W-1:0] cand_val,
    input  logic [IDX_W-1:0] cand_idx,
    input  logic [VAL_W-1:0] best_val,
    input  logic [IDX_W-1:0] best_idx,
    output logic [VAL_W-1:0] next_val,
    output logic [IDX_W-1:0] next_idx
);

    // Replace the best only when the candidate is strictly larger.
    always_comb begin
        next_val = best_val;
        next_idx = best_idx;
        if ($signed(cand_val) > $signed(best_val)) begin
            next_val = cand_val;
            next_idx = cand_idx;
        end else begin
            next_val = best_val;
            next_idx = best_idx;
        end
    end

endmodule

// File: rtl/neuron_argmax.sv
// Snapshots all neuron sums once the layer is done, scans them one per clock,
// and hands the winning class index and value downstream over valid/ready.
module neuron_argmax #(
    parameter int NUM_NEURONS  = neuron_argmax_pkg::NUM_NEURONS,
    parameter int OUTPUT_WIDTH = neuron_argmax_pkg::OUTPUT_WIDTH,
    parameter int IDX_WIDTH    = neuron_argmax_pkg::IDX_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] NEURON_OUTS,
    input  logic [NUM_NEURONS-1:0]            NEURON_DONE,
    input  logic                              RESULT_READY,
    output logic                              RESULT_VALID,
    output logic [IDX_WIDTH-1:0]              CLASS_OUT,
    output logic [OUTPUT_WIDTH-1:0]           MAX_VAL,
    output logic                              BUSY
);

    import neuron_argmax_pkg::*;

    state_t                  state_r;
    logic [OUTPUT_WIDTH-1:0] snap_r [NUM_NEURONS];
    logic [IDX_WIDTH-1:0]    idx_r;
    logic [OUTPUT_WIDTH-1:0] best_val_r;
    logic [IDX_WIDTH-1:0]    best_idx_r;
    logic                    valid_r;
    logic [IDX_WIDTH-1:0]    class_r;
    logic [OUTPUT_WIDTH-1:0] max_r;
    logic                    busy_r;

    logic                    all_done_s;
    logic [OUTPUT_WIDTH-1:0] cand_val_s;
    logic [OUTPUT_WIDTH-1:0] next_val_s;
    logic [IDX_WIDTH-1:0]    next_idx_s;

    assign all_done_s = &NEURON_DONE;
    assign cand_val_s = snap_r[idx_r];

    argmax_cmp_sel #(
        .VAL_W (OUTPUT_WIDTH),
        .IDX_W (IDX_WIDTH)
    ) u_cmp_sel (
        .cand_val (cand_val_s),
        .cand_idx (idx_r),
        .best_val (best_val_r),
        .best_idx (best_idx_r),
        .next_val (next_val_s),
        .next_idx (next_idx_s)
    );

    // Control FSM, snapshot bank, scan counter and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                snap_r[k] <= {OUTPUT_WIDTH{1'b0}};
            end
            idx_r      <= {IDX_WIDTH{1'b0}};
            best_val_r <= {OUTPUT_WIDTH{1'b0}};
            best_idx_r <= {IDX_WIDTH{1'b0}};
            valid_r    <= 1'b0;
            class_r    <= {IDX_WIDTH{1'b0}};
            max_r      <= {OUTPUT_WIDTH{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (all_done_s) begin
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            snap_r[k] <= NEURON_OUTS[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                        end
                        // Neuron 0 seeds the best, so the scan starts at index 1.
                        best_val_r <= NEURON_OUTS[OUTPUT_WIDTH-1:0];
                        best_idx_r <= {IDX_WIDTH{1'b0}};
                        idx_r      <= IDX_WIDTH'(1);
                        busy_r     <= 1'b1;
                        state_r    <= SCAN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    best_val_r <= next_val_s;
                    best_idx_r <= next_idx_s;
                    idx_r      <= idx_r + IDX_WIDTH'(1);
                    if (idx_r == IDX_WIDTH'(NUM_NEURONS - 1)) begin
                        class_r <= next_idx_s;
                        max_r   <= next_val_s;
                        valid_r <= 1'b1;
                        state_r <= RESULT;
                    end else begin
                        state_r <= SCAN;
                    end
                end
                RESULT: begin
                    if (RESULT_READY) begin
                        valid_r <= 1'b0;
                        // Done bits still held means the same image: wait them out.
                        if (all_done_s) begin
                            state_r <= CLEAR;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!all_done_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= CLEAR;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign RESULT_VALID = valid_r;
    assign CLASS_OUT    = class_r;
    assign MAX_VAL      = max_r;
    assign BUSY         = busy_r;

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed self-checking bench for neuron_argmax using immediate assertions.
module tb_neuron_argmax;

    localparam int NN = 10;
    localparam int W  = 26;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NN*W-1:0] NEURON_OUTS;
    logic [NN-1:0]   NEURON_DONE;
    logic            RESULT_READY;
    logic            RESULT_VALID;
    logic [IW-1:0]   CLASS_OUT;
    logic [W-1:0]    MAX_VAL;
    logic            BUSY;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat;
    logic       seen;
    logic [W-1:0] sums [NN];

    neuron_argmax dut (
        .clk          (clk),
        .rst          (rst),
        .NEURON_OUTS  (NEURON_OUTS),
        .NEURON_DONE  (NEURON_DONE),
        .RESULT_READY (RESULT_READY),
        .RESULT_VALID (RESULT_VALID),
        .CLASS_OUT    (CLASS_OUT),
        .MAX_VAL      (MAX_VAL),
        .BUSY         (BUSY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_sums();
        for (int k = 0; k < NN; k++) begin
            NEURON_OUTS[k*W +: W] = sums[k];
        end
    endtask

    task automatic fill_sums(input logic [W-1:0] v);
        for (int k = 0; k < NN; k++) begin
            sums[k] = v;
        end
    endtask

    // Called #1 after the capture edge; counts edges until VALID is seen.
    task automatic wait_result(input string tag);
        lat = 0;
        while (RESULT_VALID !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd9);
    endtask

    task automatic run_scan(input string tag, input logic [IW-1:0] exp_cls, input logic [W-1:0] exp_max);
        apply_sums();
        NEURON_DONE = {NN{1'b1}};
        step();
        wait_result(tag);
        check({tag, "_class"}, 32'(CLASS_OUT), 32'(exp_cls));
        check({tag, "_max"},   32'(MAX_VAL),   32'(exp_max));
        check({tag, "_busy"},  32'(BUSY),      32'd1);
    endtask

    // Transfer with READY high, then drop the done bits and expect IDLE.
    task automatic finish_xfer(input string tag);
        step();
        check({tag, "_pulse"}, 32'(RESULT_VALID), 32'd0);
        check({tag, "_clear"}, 32'(BUSY),         32'd1);
        NEURON_DONE = {NN{1'b0}};
        step();
        check({tag, "_idle"},  32'(BUSY),         32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        NEURON_OUTS  = {NN*W{1'b0}};
        NEURON_DONE  = {NN{1'b0}};
        RESULT_READY = 1'b0;
        repeat (2) step();
        check("rst_valid", 32'(RESULT_VALID), 32'd0);
        check("rst_busy",  32'(BUSY),         32'd0);
        check("rst_class", 32'(CLASS_OUT),    32'd0);
        check("rst_max",   32'(MAX_VAL),      32'd0);
        rst = 1'b1;
        step();

        // Basic pick: 0.0 .. 9.0, winner is the last neuron.
        for (int k = 0; k < NN; k++) sums[k] = W'(k * 32'h40000);
        RESULT_READY = 1'b1;
        run_scan("basic", 4'd9, 26'h0240000);
        finish_xfer("basic");

        // Signed compare, including the most negative value.
        fill_sums(26'h3FC0000);
        sums[0] = 26'h2000000;
        sums[3] = 26'h3FFFFFF;
        run_scan("neg", 4'd3, 26'h3FFFFFF);
        finish_xfer("neg");

        // Tie keeps the lower index.
        fill_sums(26'h0000000);
        sums[2] = 26'h0100000;
        sums[7] = 26'h0100000;
        run_scan("tie", 4'd2, 26'h0100000);
        finish_xfer("tie");

        // Backpressure, then rearm with done held through the transfer.
        fill_sums(26'h0000000);
        sums[8] = 26'h0080000;
        RESULT_READY = 1'b0;
        run_scan("bp", 4'd8, 26'h0080000);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_stall_valid", 32'(RESULT_VALID), 32'd1);
            check("bp_stall_class", 32'(CLASS_OUT),    32'd8);
            check("bp_stall_max",   32'(MAX_VAL),      32'h0080000);
        end
        RESULT_READY = 1'b1;
        step();
        check("bp_xfer_valid", 32'(RESULT_VALID), 32'd0);
        fill_sums(26'h0000001);
        sums[5] = 26'h1FFFFFF;
        apply_sums();
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_clear_busy",  32'(BUSY),         32'd1);
            check("bp_clear_valid", 32'(RESULT_VALID), 32'd0);
        end
        NEURON_DONE = {NN{1'b0}};
        step();
        check("bp_idle", 32'(BUSY), 32'd0);
        run_scan("rearm", 4'd5, 26'h1FFFFFF);
        finish_xfer("rearm");

        // Partial done never starts a scan.
        fill_sums(26'h0010000);
        sums[4] = 26'h0050000;
        apply_sums();
        NEURON_DONE = 10'h3FE;
        seen = 1'b0;
        repeat (20) begin
            step();
            seen = seen | BUSY | RESULT_VALID;
        end
        check("partial_idle", 32'(seen), 32'd0);

        // Snapshot is authoritative after capture.
        NEURON_DONE = {NN{1'b1}};
        step();
        fill_sums(26'h0000000);
        sums[6] = 26'h1FFFFFF;
        apply_sums();
        wait_result("snap");
        check("snap_class", 32'(CLASS_OUT), 32'd4);
        check("snap_max",   32'(MAX_VAL),   32'h0050000);
        finish_xfer("snap");

        // Asynchronous reset mid-scan, then a fresh capture.
        for (int k = 0; k < NN; k++) sums[k] = W'(k * 32'h40000);
        apply_sums();
        NEURON_DONE = {NN{1'b1}};
        step();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(RESULT_VALID), 32'd0);
        check("arst_busy",  32'(BUSY),         32'd0);
        check("arst_class", 32'(CLASS_OUT),    32'd0);
        check("arst_max",   32'(MAX_VAL),      32'd0);
        #2;
        rst = 1'b1;
        step();
        check("arst_recapture_busy", 32'(BUSY), 32'd1);
        wait_result("arst");
        check("arst_class2", 32'(CLASS_OUT), 32'd9);
        check("arst_max2",   32'(MAX_VAL),   32'h0240000);
        finish_xfer("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
